// File: rtl/tile_out_scheduler_pkg.sv
// Shared types and widths for the output-tile write-back scheduler.
package tile_sched_pkg;

  localparam int unsigned DIM_W  = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CH_W   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StAdvance,
    StFin
  } tile_sched_state_e;

  // Tile descriptor as seen by the compute engine.
  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic [DIM_W-1:0]  h;
    logic [DIM_W-1:0]  w;
    logic [ADDR_W-1:0] base;
  } tile_desc_t;

  // Elements per channel plane; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] plane_size(input logic [DIM_W-1:0] h,
                                                   input logic [DIM_W-1:0] w);
    logic [2*DIM_W-1:0] p;
    p = h * w;
    return ADDR_W'(p);
  endfunction

endpackage

// File: rtl/tile_out_scheduler_if.sv
// Configuration, tile handshake and writer launch bundle for tile_out_scheduler.
interface tile_out_scheduler_if;
  import tile_sched_pkg::*;

  logic              start;
  logic [DIM_W-1:0]  cfg_img_h;
  logic [DIM_W-1:0]  cfg_img_w;
  logic [DIM_W-1:0]  cfg_tile_h;
  logic [DIM_W-1:0]  cfg_tile_w;
  logic [CH_W-1:0]   cfg_num_ch;
  logic [ADDR_W-1:0] cfg_base_addr;

  logic              tile_valid;
  logic              tile_ready;
  logic [CH_W-1:0]   tile_ch;

  logic              wr_start;
  logic [DIM_W-1:0]  wr_img_h;
  logic [DIM_W-1:0]  wr_img_w;
  logic [ADDR_W-1:0] wr_base_addr;
  logic [DIM_W-1:0]  wr_tile_out_row;
  logic [DIM_W-1:0]  wr_tile_out_col;
  logic [DIM_W-1:0]  wr_tile_out_h;
  logic [DIM_W-1:0]  wr_tile_out_w;
  logic              wr_done;

  logic              busy;
  logic              done;

  // Scheduler side.
  modport master (
    input  start, cfg_img_h, cfg_img_w, cfg_tile_h, cfg_tile_w, cfg_num_ch, cfg_base_addr,
    input  tile_ready, wr_done,
    output tile_valid, tile_ch, wr_start, wr_img_h, wr_img_w, wr_base_addr,
    output wr_tile_out_row, wr_tile_out_col, wr_tile_out_h, wr_tile_out_w, busy, done
  );

  // Controller / compute engine / writer side.
  modport slave (
    output start, cfg_img_h, cfg_img_w, cfg_tile_h, cfg_tile_w, cfg_num_ch, cfg_base_addr,
    output tile_ready, wr_done,
    input  tile_valid, tile_ch, wr_start, wr_img_h, wr_img_w, wr_base_addr,
    input  wr_tile_out_row, wr_tile_out_col, wr_tile_out_h, wr_tile_out_w, busy, done
  );

endinterface

// File: rtl/tile_out_scheduler_tile_clip.sv
// Edge-tile clipping for one dimension: min(tile, extent - origin).
module tile_clip
  import tile_sched_pkg::*;
(
  input  logic [DIM_W-1:0] i_tile,
  input  logic [DIM_W-1:0] i_extent,
  input  logic [DIM_W-1:0] i_origin,
  output logic [DIM_W-1:0] o_size
);

  logic [DIM_W-1:0] w_remain;

  // Origin is always below extent when this result is used, so no underflow.
  always_comb begin
    w_remain = i_extent - i_origin;
    o_size   = (i_tile < w_remain) ? i_tile : w_remain;
  end

endmodule

// File: rtl/tile_out_scheduler.sv
// Walks a C x H x W output image tile by tile, handshakes each descriptor and
// launches the tile writer, waiting for its completion before moving on.
module tile_out_scheduler
  import tile_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  tile_out_scheduler_if.master bus
);

  tile_sched_state_e r_state, w_state_next;

  logic [DIM_W-1:0]  r_img_h, r_img_w, r_tile_h, r_tile_w;
  logic [CH_W-1:0]   r_num_ch;
  logic [ADDR_W-1:0] r_plane;
  tile_desc_t        r_desc;
  logic              r_wr_start;

  logic [DIM_W:0]    w_col_sum, w_row_sum;
  logic              w_col_wrap, w_row_wrap, w_last, w_cfg_zero;
  logic [CH_W:0]     w_ch_inc;
  logic [DIM_W-1:0]  w_next_row, w_next_col;
  logic [DIM_W-1:0]  w_clip_tile_h, w_clip_img_h, w_clip_row;
  logic [DIM_W-1:0]  w_clip_tile_w, w_clip_img_w, w_clip_col;
  logic [DIM_W-1:0]  w_clip_h, w_clip_w;

  // Next tile position; compares are one bit wider so the sums cannot wrap.
  always_comb begin
    w_col_sum  = {1'b0, r_desc.col} + {1'b0, r_tile_w};
    w_col_wrap = (w_col_sum >= {1'b0, r_img_w});
    w_row_sum  = {1'b0, r_desc.row} + {1'b0, r_tile_h};
    w_row_wrap = w_col_wrap && (w_row_sum >= {1'b0, r_img_h});
    w_ch_inc   = {1'b0, r_desc.ch} + 1'b1;
    w_last     = w_row_wrap && (w_ch_inc == {1'b0, r_num_ch});
    w_next_col = w_col_wrap ? '0 : w_col_sum[DIM_W-1:0];
    w_next_row = w_row_wrap ? '0 : (w_col_wrap ? w_row_sum[DIM_W-1:0] : r_desc.row);
    w_cfg_zero = (bus.cfg_img_h == '0) || (bus.cfg_img_w == '0) || (bus.cfg_tile_h == '0) ||
                 (bus.cfg_tile_w == '0) || (bus.cfg_num_ch == '0);
  end

  // Clip inputs come straight from cfg on start (not yet latched), else from registers.
  always_comb begin
    if (r_state == StIdle) begin
      w_clip_tile_h = bus.cfg_tile_h;
      w_clip_img_h  = bus.cfg_img_h;
      w_clip_row    = '0;
      w_clip_tile_w = bus.cfg_tile_w;
      w_clip_img_w  = bus.cfg_img_w;
      w_clip_col    = '0;
    end else begin
      w_clip_tile_h = r_tile_h;
      w_clip_img_h  = r_img_h;
      w_clip_row    = w_next_row;
      w_clip_tile_w = r_tile_w;
      w_clip_img_w  = r_img_w;
      w_clip_col    = w_next_col;
    end
  end

  tile_clip u_clip_h (
    .i_tile   (w_clip_tile_h),
    .i_extent (w_clip_img_h),
    .i_origin (w_clip_row),
    .o_size   (w_clip_h)
  );

  tile_clip u_clip_w (
    .i_tile   (w_clip_tile_w),
    .i_extent (w_clip_img_w),
    .i_origin (w_clip_col),
    .o_size   (w_clip_w)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (bus.start) w_state_next = w_cfg_zero ? StFin : StIssue;
      StIssue:   if (bus.tile_ready) w_state_next = StWait;
      StWait:    if (bus.wr_done) w_state_next = StAdvance;
      StAdvance: w_state_next = w_last ? StFin : StIssue;
      StFin:     w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state plus registered descriptor fields.
  always_comb begin
    bus.tile_valid      = (r_state == StIssue);
    bus.busy            = (r_state != StIdle);
    bus.done            = (r_state == StFin);
    bus.wr_start        = r_wr_start;
    bus.tile_ch         = r_desc.ch;
    bus.wr_img_h        = r_img_h;
    bus.wr_img_w        = r_img_w;
    bus.wr_base_addr    = r_desc.base;
    bus.wr_tile_out_row = r_desc.row;
    bus.wr_tile_out_col = r_desc.col;
    bus.wr_tile_out_h   = r_desc.h;
    bus.wr_tile_out_w   = r_desc.w;
  end

  // Config latch, tile walk and writer start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_img_h    <= '0;
      r_img_w    <= '0;
      r_tile_h   <= '0;
      r_tile_w   <= '0;
      r_num_ch   <= '0;
      r_plane    <= '0;
      r_desc     <= '0;
      r_wr_start <= 1'b0;
    end else begin
      r_wr_start <= (r_state == StIssue) && bus.tile_ready;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_img_h     <= bus.cfg_img_h;
            r_img_w     <= bus.cfg_img_w;
            r_tile_h    <= bus.cfg_tile_h;
            r_tile_w    <= bus.cfg_tile_w;
            r_num_ch    <= bus.cfg_num_ch;
            r_plane     <= plane_size(bus.cfg_img_h, bus.cfg_img_w);
            r_desc.ch   <= '0;
            r_desc.row  <= '0;
            r_desc.col  <= '0;
            r_desc.h    <= w_clip_h;
            r_desc.w    <= w_clip_w;
            r_desc.base <= bus.cfg_base_addr;
          end
        end
        StAdvance: begin
          r_desc.row <= w_next_row;
          r_desc.col <= w_next_col;
          r_desc.h   <= w_clip_h;
          r_desc.w   <= w_clip_w;
          if (w_row_wrap) begin
            r_desc.ch   <= w_ch_inc[CH_W-1:0];
            r_desc.base <= r_desc.base + r_plane;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_out_scheduler.sv
// Directed bench for tile_out_scheduler: clipping, channel rollover, backpressure,
// zero-size config, ignored spurious inputs and mid-run reset.
module tb_tile_out_scheduler;
  import tile_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tile_out_scheduler_if bus ();

  tile_out_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_desc(input string tag, input int ch, input int row, input int col,
                          input int h, input int w, input logic [31:0] base);
    chk({tag, ".ch"},   32'(bus.tile_ch),         32'(ch));
    chk({tag, ".row"},  32'(bus.wr_tile_out_row), 32'(row));
    chk({tag, ".col"},  32'(bus.wr_tile_out_col), 32'(col));
    chk({tag, ".h"},    32'(bus.wr_tile_out_h),   32'(h));
    chk({tag, ".w"},    32'(bus.wr_tile_out_w),   32'(w));
    chk({tag, ".base"}, bus.wr_base_addr,         base);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(bus.tile_valid), 32'd0);
    chk({tag, ".busy"},  32'(bus.busy),       32'd0);
    chk({tag, ".done"},  32'(bus.done),       32'd0);
    chk({tag, ".wrst"},  32'(bus.wr_start),   32'd0);
    chk({tag, ".imgh"},  32'(bus.wr_img_h),   32'd0);
    chk({tag, ".imgw"},  32'(bus.wr_img_w),   32'd0);
    chk_desc(tag, 0, 0, 0, 0, 0, 32'd0);
  endtask

  // One tile from ISSUE arrival through ADVANCE; returns at the following cycle.
  task automatic do_tile(input int ch, input int row, input int col, input int h, input int w,
                         input logic [31:0] base, input int stall, input bit spur);
    chk("issue.valid", 32'(bus.tile_valid), 32'd1);
    chk("issue.wrst",  32'(bus.wr_start),   32'd0);
    chk_desc("issue", ch, row, col, h, w, base);
    for (int i = 0; i < stall; i++) begin
      bus.tile_ready = 1'b0;
      if (spur && i == 0) begin
        bus.start   = 1'b1;
        bus.wr_done = 1'b1;
      end
      step();
      bus.start   = 1'b0;
      bus.wr_done = 1'b0;
      chk("stall.valid", 32'(bus.tile_valid), 32'd1);
      chk("stall.wrst",  32'(bus.wr_start),   32'd0);
      chk_desc("stall", ch, row, col, h, w, base);
    end
    bus.tile_ready = 1'b1;
    step();
    bus.tile_ready = 1'b0;
    chk("fire.wrst",  32'(bus.wr_start),   32'd1);
    chk("fire.valid", 32'(bus.tile_valid), 32'd0);
    chk_desc("fire", ch, row, col, h, w, base);
    step();
    chk("wait.wrst", 32'(bus.wr_start), 32'd0);
    chk("wait.busy", 32'(bus.busy),     32'd1);
    step();
    step();
    bus.wr_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
    chk("adv.valid", 32'(bus.tile_valid), 32'd0);
    chk("adv.busy",  32'(bus.busy),       32'd1);
    chk("adv.done",  32'(bus.done),       32'd0);
    step();
  endtask

  task automatic start_run(input int img_h, input int img_w, input int nch);
    bus.cfg_img_h     = 16'(img_h);
    bus.cfg_img_w     = 16'(img_w);
    bus.cfg_tile_h    = 16'd2;
    bus.cfg_tile_w    = 16'd3;
    bus.cfg_num_ch    = 16'(nch);
    bus.cfg_base_addr = 32'h1000;
    bus.start         = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start.busy", 32'(bus.busy), 32'd1);
  endtask

  // 5x7 image, 2x3 tiles: rows 0/2/4 (h 2/2/1), cols 0/3/6 (w 3/3/1), plane 35.
  task automatic run_image(input int nch, input int stall, input bit spur);
    int rows[3];
    int hs[3];
    int cols[3];
    int ws[3];
    rows = '{0, 2, 4};
    hs   = '{2, 2, 1};
    cols = '{0, 3, 6};
    ws   = '{3, 3, 1};
    for (int c = 0; c < nch; c++)
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          do_tile(c, rows[r], cols[k], hs[r], ws[k], 32'h1000 + 32'(c * 35), stall, spur);
    chk("fin.done",  32'(bus.done),       32'd1);
    chk("fin.busy",  32'(bus.busy),       32'd1);
    chk("fin.valid", 32'(bus.tile_valid), 32'd0);
    step();
    chk("post.done", 32'(bus.done), 32'd0);
    chk("post.busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.start         = 1'b0;
    bus.tile_ready    = 1'b0;
    bus.wr_done       = 1'b0;
    bus.cfg_img_h     = '0;
    bus.cfg_img_w     = '0;
    bus.cfg_tile_h    = '0;
    bus.cfg_tile_w    = '0;
    bus.cfg_num_ch    = '0;
    bus.cfg_base_addr = '0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // Clipped 5x7 image, one channel.
    start_run(5, 7, 1);
    chk("cfg.imgh", 32'(bus.wr_img_h), 32'd5);
    chk("cfg.imgw", 32'(bus.wr_img_w), 32'd7);
    run_image(1, 0, 1'b0);

    // Channel rollover.
    start_run(5, 7, 2);
    run_image(2, 0, 1'b0);

    // Backpressure.
    start_run(5, 7, 1);
    run_image(1, 5, 1'b0);

    // Zero-size config.
    start_run(5, 0, 1);
    chk("zero.done",  32'(bus.done),       32'd1);
    chk("zero.valid", 32'(bus.tile_valid), 32'd0);
    chk("zero.wrst",  32'(bus.wr_start),   32'd0);
    step();
    chk("zero.done2",  32'(bus.done),       32'd0);
    chk("zero.busy2",  32'(bus.busy),       32'd0);
    chk("zero.valid2", 32'(bus.tile_valid), 32'd0);
    chk("zero.wrst2",  32'(bus.wr_start),   32'd0);

    // Spurious start / wr_done during ISSUE.
    start_run(5, 7, 1);
    run_image(1, 1, 1'b1);

    // Mid-run reset during WAIT of tile 4, then replay from the origin.
    start_run(5, 7, 1);
    do_tile(0, 0, 0, 2, 3, 32'h1000, 0, 1'b0);
    do_tile(0, 0, 3, 2, 3, 32'h1000, 0, 1'b0);
    do_tile(0, 0, 6, 2, 1, 32'h1000, 0, 1'b0);
    chk("t4.valid", 32'(bus.tile_valid), 32'd1);
    chk_desc("t4", 0, 2, 0, 2, 3, 32'h1000);
    bus.tile_ready = 1'b1;
    step();
    bus.tile_ready = 1'b0;
    chk("t4.wrst", 32'(bus.wr_start), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("midrst");
    step();
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    start_run(5, 7, 1);
    run_image(1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
